cam_cmd_sequencer: RTL and testbench

//   Synthesizable initiator for the cam command interface. It accepts high-level ops (SET_ALL, SEARCH,

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_tag_popcount.sv | 17 +
 rtl/cam_cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cam_cmd_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared opcodes, FSM state encoding and default timing for the cam command sequencer.
package cam_pkg;

    localparam logic [2:0] OP_SET_ALL      = 3'd0;
    localparam logic [2:0] OP_SEARCH       = 3'd1;
    localparam logic [2:0] OP_SELECT_FIRST = 3'd2;
    localparam logic [2:0] OP_WRITE        = 3'd3;
    localparam logic [2:0] OP_READ         = 3'd4;

    localparam int DEF_NUM_BITS      = 32;
    localparam int DEF_NUM_CELLS     = 100;
    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_READ);
    endfunction

endpackage

// File: rtl/cam_tag_popcount.sv
// Combinational count of set tag wires; the caller registers the result.
module cam_tag_popcount #(
    parameter int NUM_CELLS = 100,
    parameter int CW        = $clog2(NUM_CELLS + 1)
) (
    input  logic [NUM_CELLS-1:0] i_tags,
    output logic [CW-1:0]        o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            o_count = o_count + CW'(i_tags[i]);
        end
    end

endmodule

// File: rtl/cam_cmd_sequencer.sv
// Command-level initiator for one cam instance: turns valid/ready ops into timed strobe pulses
// and returns sampled tag/read results on a valid/ready response port.
module cam_cmd_sequencer
    import cam_pkg::*;
#(
    parameter int NUM_BITS      = DEF_NUM_BITS,
    parameter int NUM_CELLS     = DEF_NUM_CELLS,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CW            = $clog2(NUM_CELLS + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [NUM_BITS-1:0]   cmd_data,
    input  logic [NUM_BITS-1:0]   cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NUM_BITS-1:0]   rsp_data,
    output logic                  rsp_any,
    output logic [CW-1:0]         rsp_count,
    output logic                  rsp_err,
    output logic [NUM_BITS-1:0]   cam_comparand,
    output logic [NUM_BITS-1:0]   cam_mask,
    output logic                  cam_set,
    output logic                  cam_perform_search,
    output logic                  cam_select_first,
    output logic [2*NUM_BITS-1:0] cam_write_lines,
    input  logic [NUM_CELLS-1:0]  cam_tag_wires,
    input  logic [NUM_BITS-1:0]   cam_read_lines,
    output logic [1:0]            dbg_state
);

    localparam int MAX_LEN = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic [2:0]            r_op;
    logic [NUM_BITS-1:0]   r_data;
    logic [NUM_BITS-1:0]   r_mask;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_phase;
    logic                  r_set;
    logic                  r_search;
    logic                  r_select;
    logic [2*NUM_BITS-1:0] r_wl;
    logic                  r_rsp_valid;
    logic [NUM_BITS-1:0]   r_rsp_data;
    logic                  r_rsp_any;
    logic [CW-1:0]         r_rsp_count;
    logic                  r_rsp_err;

    logic [2*NUM_BITS-1:0] w_write_lines;
    logic [CW-1:0]         w_tag_count;

    // Each bit drives a {clear,set} pair; masked-off bits leave both lines low.
    always_comb begin
        w_write_lines = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            w_write_lines[2*i]   = cmd_data[i] & cmd_mask[i];
            w_write_lines[2*i+1] = ~cmd_data[i] & cmd_mask[i];
        end
    end

    cam_tag_popcount #(.NUM_CELLS(NUM_CELLS), .CW(CW)) u_popcount (
        .i_tags  (cam_tag_wires),
        .o_count (w_tag_count)
    );

    // Both ports transfer on a cycle where valid&ready are high; cmd_ready is high only in IDLE,
    // and a response holds all rsp_* fields until rsp_ready is seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_op        <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
            r_set       <= 1'b0;
            r_search    <= 1'b0;
            r_select    <= 1'b0;
            r_wl        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_any   <= 1'b0;
            r_rsp_count <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_data      <= cmd_data;
                        r_mask      <= cmd_mask;
                        r_phase     <= 1'b0;
                        if (op_is_legal(cmd_op)) begin
                            r_state  <= ST_PULSE;
                            r_cnt    <= CNT_W'(PULSE_CYCLES - 1);
                            r_set    <= (cmd_op == OP_SET_ALL) || (cmd_op == OP_SEARCH);
                            r_select <= (cmd_op == OP_SELECT_FIRST);
                            r_wl     <= (cmd_op == OP_WRITE) ? w_write_lines : '0;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_any   <= 1'b0;
                            r_rsp_count <= '0;
                        end
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_set    <= 1'b0;
                        r_search <= 1'b0;
                        r_select <= 1'b0;
                        r_wl     <= '0;
                        r_state  <= ST_SETTLE;
                        r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if ((r_op == OP_SEARCH) && !r_phase) begin
                        r_phase  <= 1'b1;
                        r_state  <= ST_PULSE;
                        r_cnt    <= CNT_W'(PULSE_CYCLES - 1);
                        r_search <= 1'b1;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= (r_op == OP_READ) ? cam_read_lines : '0;
                        r_rsp_any   <= |cam_tag_wires;
                        r_rsp_count <= w_tag_count;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready          = r_cmd_ready;
    assign rsp_valid          = r_rsp_valid;
    assign rsp_data           = r_rsp_data;
    assign rsp_any            = r_rsp_any;
    assign rsp_count          = r_rsp_count;
    assign rsp_err            = r_rsp_err;
    assign cam_comparand      = r_data;
    assign cam_mask           = r_mask;
    assign cam_set            = r_set;
    assign cam_perform_search = r_search;
    assign cam_select_first   = r_select;
    assign cam_write_lines    = r_wl;
    assign dbg_state          = r_state;

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Bench for cam_cmd_sequencer: a pin-level cam model answers the strobes, and a transaction-level
// reference computes the expected responses and strobe timing for every command.
module tb_cam_cmd_sequencer;
    import cam_pkg::*;

    localparam int NB = 8;
    localparam int NC = 4;
    localparam int P  = 2;
    localparam int S  = 3;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic [NB-1:0]   cmd_data = '0;
    logic [NB-1:0]   cmd_mask = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [NB-1:0]   rsp_data;
    logic            rsp_any;
    logic [CW-1:0]   rsp_count;
    logic            rsp_err;
    logic [NB-1:0]   cam_comparand;
    logic [NB-1:0]   cam_mask;
    logic            cam_set;
    logic            cam_perform_search;
    logic            cam_select_first;
    logic [2*NB-1:0] cam_write_lines;
    logic [NC-1:0]   cam_tag_wires;
    logic [NB-1:0]   cam_read_lines;
    logic [1:0]      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_cmd_sequencer #(
        .NUM_BITS(NB), .NUM_CELLS(NC), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
    ) dut (
        .CLK(clk), .RST(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_any(rsp_any), .rsp_count(rsp_count), .rsp_err(rsp_err),
        .cam_comparand(cam_comparand), .cam_mask(cam_mask), .cam_set(cam_set),
        .cam_perform_search(cam_perform_search), .cam_select_first(cam_select_first),
        .cam_write_lines(cam_write_lines), .cam_tag_wires(cam_tag_wires),
        .cam_read_lines(cam_read_lines), .dbg_state(dbg_state)
    );

    // Pin-level cam: reacts to whatever strobes are high at each edge.
    logic [NB-1:0] m_cells [NC] = '{8'd0, 8'd3, 8'd0, 8'd7};
    logic [NC-1:0] m_tags = '0;

    always @(posedge clk) begin
        if (cam_set) m_tags <= '1;
        if (cam_perform_search)
            for (int c = 0; c < NC; c++)
                if (((m_cells[c] ^ cam_comparand) & cam_mask) != '0) m_tags[c] <= 1'b0;
        if (cam_select_first) m_tags <= m_tags & (~m_tags + 4'd1);
        for (int c = 0; c < NC; c++)
            if (m_tags[c])
                for (int b = 0; b < NB; b++) begin
                    if (cam_write_lines[2*b])   m_cells[c][b] <= 1'b1;
                    if (cam_write_lines[2*b+1]) m_cells[c][b] <= 1'b0;
                end
    end

    assign cam_tag_wires = m_tags;
    always_comb begin
        cam_read_lines = '0;
        for (int c = 0; c < NC; c++)
            if (m_tags[c]) cam_read_lines = cam_read_lines | m_cells[c];
    end

    // Transaction-level reference: {err, any, count, data} per command.
    logic [NB-1:0]   ref_cells [NC] = '{8'd0, 8'd3, 8'd0, 8'd7};
    logic [NC-1:0]   ref_tags = '0;
    logic [12:0]     exp_q[$];
    int              exp_lat, exp_set_n, exp_ps_n, exp_sf_n, exp_wl_n;
    logic [2*NB-1:0] exp_wl;

    task automatic ref_apply(input logic [2:0] op, input logic [NB-1:0] d, input logic [NB-1:0] m);
        logic [NB-1:0] rd;
        bit found;
        logic [CW-1:0] cnt;
        rd = '0; found = 0;
        exp_set_n = 0; exp_ps_n = 0; exp_sf_n = 0; exp_wl_n = 0; exp_wl = '0;
        exp_lat = P + S + 1;
        case (op)
            3'd0: begin ref_tags = '1; exp_set_n = P; end
            3'd1: begin
                ref_tags = '1;
                for (int c = 0; c < NC; c++)
                    if (((ref_cells[c] ^ d) & m) != '0) ref_tags[c] = 1'b0;
                exp_set_n = P; exp_ps_n = P; exp_lat = 2 * (P + S) + 1;
            end
            3'd2: begin
                for (int c = 0; c < NC; c++)
                    if (ref_tags[c]) begin
                        if (found) ref_tags[c] = 1'b0;
                        found = 1;
                    end
                exp_sf_n = P;
            end
            3'd3: begin
                for (int c = 0; c < NC; c++)
                    if (ref_tags[c]) ref_cells[c] = (ref_cells[c] & ~m) | (d & m);
                for (int b = 0; b < NB; b++) begin
                    exp_wl[2*b]   = d[b] & m[b];
                    exp_wl[2*b+1] = ~d[b] & m[b];
                end
                exp_wl_n = (m != '0) ? P : 0;
            end
            3'd4: for (int c = 0; c < NC; c++) if (ref_tags[c]) rd = rd | ref_cells[c];
            default: exp_lat = 1;
        endcase
        cnt = CW'($countones(ref_tags));
        if (op > 3'd4) exp_q.push_back(13'd0 | 13'h1000);
        else           exp_q.push_back({1'b0, ref_tags != '0, cnt, rd});
    endtask

    // Observations gathered by the driver for the test tasks to judge.
    int              o_lat, o_set_n, o_set_first, o_ps_n, o_ps_first, o_sf_n, o_wl_n;
    int              o_overlap, o_unstable, o_busy_ready;
    logic [2*NB-1:0] o_wl;
    logic [12:0]     o_rsp;
    logic            o_ready_after;

    task automatic sample_pins(input int k);
        int groups;
        groups = int'(cam_set) + int'(cam_perform_search) + int'(cam_select_first)
               + int'(cam_write_lines != '0);
        if (groups > 1) o_overlap++;
        if (cmd_ready) o_busy_ready++;
        if (cam_set) begin o_set_n++; if (o_set_first == 0) o_set_first = k; end
        if (cam_perform_search) begin o_ps_n++; if (o_ps_first == 0) o_ps_first = k; end
        if (cam_select_first) o_sf_n++;
        if (cam_write_lines != '0) begin o_wl_n++; o_wl = cam_write_lines; end
    endtask

    // Called at a negedge; returns at the negedge just after the response handshake.
    task automatic do_op(input logic [2:0] op, input logic [NB-1:0] d, input logic [NB-1:0] m,
                         input bit keep_valid, input int hold);
        int k;
        o_set_n = 0; o_set_first = 0; o_ps_n = 0; o_ps_first = 0; o_sf_n = 0; o_wl_n = 0;
        o_overlap = 0; o_unstable = 0; o_busy_ready = 0; o_wl = '0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
        k = 0;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 100) begin
            sample_pins(k);
            @(negedge clk);
            k++;
        end
        o_lat = k;
        sample_pins(k);
        o_rsp = {rsp_err, rsp_any, rsp_count, rsp_data};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            sample_pins(k + h + 1);
            if (!rsp_valid || ({rsp_err, rsp_any, rsp_count, rsp_data} != o_rsp)) o_unstable++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_ready_after = cmd_ready;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({rsp_err, rsp_any, rsp_count, rsp_data} !== 13'd0) begin
            n_err++; $display("FAIL rst_rsp_fields: got %h want 0", {rsp_err, rsp_any, rsp_count, rsp_data}); end
        n_cmp++; if ({cam_comparand, cam_mask, cam_set, cam_perform_search, cam_select_first, cam_write_lines} !== 35'd0) begin
            n_err++; $display("FAIL rst_cam_outs: got %h want 0",
                {cam_comparand, cam_mask, cam_set, cam_perform_search, cam_select_first, cam_write_lines}); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        // Reset in the middle of a WRITE pulse; no cell is tagged yet so the cam is untouched.
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 8'hFF; cmd_mask = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if (cam_write_lines !== 16'h5555) begin n_err++; $display("FAIL midwr_lines_on: got %h want 5555", cam_write_lines); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (cam_write_lines !== 16'h0000) begin n_err++; $display("FAIL midwr_lines_off: got %h want 0000", cam_write_lines); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midwr_ready: got %b want 1", cmd_ready); end
        seen = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midwr_no_rsp: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_write();
        logic [12:0] e;
        ref_apply(OP_WRITE, 8'hA5, 8'h0F);
        do_op(OP_WRITE, 8'hA5, 8'h0F, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (o_wl !== exp_wl) begin n_err++; $display("FAIL wr_lines: got %h want %h", o_wl, exp_wl); end
        n_cmp++; if (o_wl !== 16'h0099) begin n_err++; $display("FAIL wr_lines_const: got %h want 0099", o_wl); end
        n_cmp++; if (o_wl_n != P) begin n_err++; $display("FAIL wr_pulse_len: got %0d want %0d", o_wl_n, P); end
        n_cmp++; if (o_lat != exp_lat) begin n_err++; $display("FAIL wr_latency: got %0d want %0d", o_lat, exp_lat); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL wr_rsp: got %h want %h", o_rsp, e); end
        n_cmp++; if (o_ready_after !== 1'b1) begin n_err++; $display("FAIL wr_ready_after: got %b want 1", o_ready_after); end
    endtask

    task automatic test_search();
        logic [12:0] e;
        ref_apply(OP_SET_ALL, 8'h00, 8'h00);
        do_op(OP_SET_ALL, 8'h00, 8'h00, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (o_set_n != exp_set_n) begin n_err++; $display("FAIL setall_len: got %0d want %0d", o_set_n, exp_set_n); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL setall_rsp: got %h want %h", o_rsp, e); end
        ref_apply(OP_SEARCH, 8'h00, 8'hFF);
        do_op(OP_SEARCH, 8'h00, 8'hFF, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (o_set_n != P || o_set_first != 1) begin
            n_err++; $display("FAIL srch_set: got len %0d at %0d want len %0d at 1", o_set_n, o_set_first, P); end
        n_cmp++; if (o_ps_n != P || o_ps_first != P + S + 1) begin
            n_err++; $display("FAIL srch_ps: got len %0d at %0d want len %0d at %0d", o_ps_n, o_ps_first, P, P + S + 1); end
        n_cmp++; if (o_overlap != 0) begin n_err++; $display("FAIL srch_overlap: got %0d want 0", o_overlap); end
        n_cmp++; if (o_lat != 2 * (P + S) + 1) begin n_err++; $display("FAIL srch_latency: got %0d want %0d", o_lat, 2 * (P + S) + 1); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL srch_rsp: got %h want %h", o_rsp, e); end
        n_cmp++; if (o_rsp[11:8] !== 4'b1010) begin n_err++; $display("FAIL srch_any_count: got %b want 1010", o_rsp[11:8]); end
    endtask

    task automatic test_select_read();
        logic [12:0] e;
        ref_apply(OP_SELECT_FIRST, 8'h00, 8'h00);
        do_op(OP_SELECT_FIRST, 8'h00, 8'h00, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (o_sf_n != P) begin n_err++; $display("FAIL sel_len: got %0d want %0d", o_sf_n, P); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL sel_rsp: got %h want %h", o_rsp, e); end
        ref_apply(OP_READ, 8'h00, 8'h00);
        do_op(OP_READ, 8'h00, 8'h00, 0, 0);
        e = exp_q.pop_front();
        n_cmp++; if (o_set_n + o_ps_n + o_sf_n + o_wl_n != 0) begin
            n_err++; $display("FAIL read_strobes: got %0d strobe cycles want 0", o_set_n + o_ps_n + o_sf_n + o_wl_n); end
        n_cmp++; if (o_lat != P + S + 1) begin n_err++; $display("FAIL read_latency: got %0d want %0d", o_lat, P + S + 1); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL read_rsp: got %h want %h", o_rsp, e); end
    endtask

    task automatic test_illegal();
        logic [12:0] e;
        ref_apply(3'd6, 8'h5A, 8'hC3);
        do_op(3'd6, 8'h5A, 8'hC3, 0, 5);
        e = exp_q.pop_front();
        n_cmp++; if (o_lat != 1) begin n_err++; $display("FAIL ill_latency: got %0d want 1", o_lat); end
        n_cmp++; if (o_set_n + o_ps_n + o_sf_n + o_wl_n != 0) begin
            n_err++; $display("FAIL ill_strobes: got %0d strobe cycles want 0", o_set_n + o_ps_n + o_sf_n + o_wl_n); end
        n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL ill_rsp: got %h want %h", o_rsp, e); end
        n_cmp++; if (o_unstable != 0) begin n_err++; $display("FAIL ill_hold_stable: got %0d changes want 0", o_unstable); end
        n_cmp++; if (o_busy_ready != 0) begin n_err++; $display("FAIL ill_busy_ready: got %0d cycles want 0", o_busy_ready); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]    q_op[$];
        logic [NB-1:0] q_d[$];
        logic [NB-1:0] q_m[$];
        logic [12:0]   e;
        int            n;
        q_op.push_back(OP_SET_ALL); q_d.push_back(8'h00); q_m.push_back(8'h00);
        q_op.push_back(OP_WRITE);   q_d.push_back(8'h00); q_m.push_back(8'hFF);
        for (int v = 1; v <= 4; v++) begin
            q_op.push_back(OP_SET_ALL);      q_d.push_back(8'h00);    q_m.push_back(8'h00);
            q_op.push_back(OP_SEARCH);       q_d.push_back(8'h00);    q_m.push_back(8'hFF);
            q_op.push_back(OP_SELECT_FIRST); q_d.push_back(8'h00);    q_m.push_back(8'h00);
            q_op.push_back(OP_WRITE);        q_d.push_back(NB'(v));   q_m.push_back(8'hFF);
        end
        q_op.push_back(OP_SEARCH); q_d.push_back(8'd35); q_m.push_back(8'hFF);
        n = q_op.size();
        for (int i = 0; i < n; i++) begin
            ref_apply(q_op[i], q_d[i], q_m[i]);
            do_op(q_op[i], q_d[i], q_m[i], i != n - 1, 0);
            e = exp_q.pop_front();
            n_cmp++; if (o_lat != exp_lat || o_overlap != 0 || o_busy_ready != 0) begin
                n_err++; $display("FAIL b2b_timing[%0d]: got lat %0d ovl %0d rdy %0d want lat %0d ovl 0 rdy 0",
                                  i, o_lat, o_overlap, o_busy_ready, exp_lat); end
            n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %h want %h", i, o_rsp, e); end
        end
        n_cmp++; if (o_rsp[11] !== 1'b0) begin n_err++; $display("FAIL b2b_search35_any: got %b want 0", o_rsp[11]); end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [NB-1:0] d, m;
        logic [12:0]   e;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = NB'($urandom_range(0, 7));
            m  = ($urandom_range(0, 3) == 0) ? 8'h00 : NB'($urandom);
            ref_apply(op, d, m);
            do_op(op, d, m, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
            e = exp_q.pop_front();
            n_cmp++; if (o_lat != exp_lat) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, o_lat, exp_lat); end
            n_cmp++; if (o_set_n != exp_set_n || o_ps_n != exp_ps_n || o_sf_n != exp_sf_n || o_wl_n != exp_wl_n) begin
                n_err++; $display("FAIL rnd_strobes[%0d]: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                    o_set_n, o_ps_n, o_sf_n, o_wl_n, exp_set_n, exp_ps_n, exp_sf_n, exp_wl_n); end
            n_cmp++; if (o_wl !== exp_wl) begin n_err++; $display("FAIL rnd_lines[%0d]: got %h want %h", i, o_wl, exp_wl); end
            n_cmp++; if (o_overlap != 0 || o_unstable != 0 || o_busy_ready != 0) begin
                n_err++; $display("FAIL rnd_protocol[%0d]: got ovl %0d unst %0d rdy %0d want 0/0/0",
                                  i, o_overlap, o_unstable, o_busy_ready); end
            n_cmp++; if (o_rsp !== e) begin n_err++; $display("FAIL rnd_rsp[%0d]: got %h want %h", i, o_rsp, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_search();
        test_select_read();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
